// File: rtl/apb_slave_pkg.sv
// ---------------------------------------------------------------------------
// apb_slave_pkg
// Shared types and constants for the APB register-bank slave.
//   state_t       : transfer FSM states (idle, wait-state countdown, ready)
//   ID_IDX        : word index of the read-only identity register
//   CNT_IDX       : word index of the read-only transfer counter
//   FIRST_RW_IDX  : first word index backed by read/write storage
//   WAIT_W        : width of the wait-state down-counter
//   DATA_W        : APB data width
// ---------------------------------------------------------------------------
package apb_slave_pkg;

    localparam int DATA_W = 32;
    localparam int WAIT_W = 4;

    localparam logic [7:0] ID_IDX       = 8'd0;
    localparam logic [7:0] CNT_IDX      = 8'd1;
    localparam logic [7:0] FIRST_RW_IDX = 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

endpackage

// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
// NUM_WORDS x DATA_W word storage.
//   PCLK   in  : clock, rising edge
//   clr    in  : synchronous clear of every word
//   we     in  : write enable for waddr/wdata
//   waddr  in  : word index written
//   wdata  in  : write data
//   raddr  in  : word index read (combinational)
//   rdata  out : contents of word raddr, 0 when raddr is out of range
// ---------------------------------------------------------------------------
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int NUM_WORDS = 256
) (
    input  logic              PCLK,
    input  logic              clr,
    input  logic              we,
    input  logic [7:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [7:0]        raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [NUM_WORDS];

    always_ff @(posedge PCLK) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (clr) begin
                mem[i] <= '0;
            end else if (we && (waddr == 8'(i))) begin
                mem[i] <= wdata;
            end
        end
    end

    // Compare-based read avoids an index wider than the array when
    // NUM_WORDS is not a power of two.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (raddr == 8'(i)) begin
                rdata = mem[i];
            end
        end
    end

endmodule

// File: rtl/apb_regbank_slave.sv
// ---------------------------------------------------------------------------
// apb_regbank_slave
// APB slave exposing an ID word, a committed-transfer counter and a block
// of read/write storage words, with a fixed number of wait states.
//   PCLK    in  : clock, rising edge
//   PRESET  in  : synchronous active-high reset
//   PSEL    in  : slave select
//   PENABLE in  : access phase
//   PWRITE  in  : 1 = write, 0 = read
//   PADDR   in  : byte address, bits [9:2] select the word
//   PWDATA  in  : write data
//   PRDATA  out : registered read data
//   PREADY  out : registered transfer complete
//   PSLVERR out : registered transfer error, only asserted with PREADY
// ---------------------------------------------------------------------------
module apb_regbank_slave
    import apb_slave_pkg::*;
#(
    parameter logic [7:0] SLAVE_ID    = 8'h00,
    parameter int         NUM_WORDS   = 256,
    parameter int         WAIT_CYCLES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] xfer_cnt;

    // Transfer captured at setup
    logic [7:0]        idx_p0;
    logic              write_p0;
    logic              err_p0;
    logic [DATA_W-1:0] wdata_p0;

    logic              setup;
    logic              capture;
    logic              commit;
    logic              enter_ready;
    logic [7:0]        live_idx;
    logic              live_err;
    logic [7:0]        sel_idx;
    logic              sel_err;
    logic              sel_wr;
    logic [DATA_W-1:0] rf_rdata;
    logic [DATA_W-1:0] rd_word;
    logic              unused_paddr;

    assign unused_paddr = ^PADDR[31:10];

    function automatic logic addr_err(input logic [31:0] addr, input logic wr);
        logic [7:0] idx;
        idx = addr[9:2];
        return (addr[1:0] != 2'b00)
            || ({24'b0, idx} >= 32'(NUM_WORDS))
            || (wr && (idx < FIRST_RW_IDX));
    endfunction

    assign setup    = PSEL && !PENABLE;
    assign live_idx = PADDR[9:2];
    assign live_err = addr_err(PADDR, PWRITE);

    // With no wait states READY is entered straight from IDLE, before the
    // setup has been captured, so the live bus is decoded in that case.
    assign sel_idx = (state == ST_IDLE) ? live_idx : idx_p0;
    assign sel_err = (state == ST_IDLE) ? live_err : err_p0;
    assign sel_wr  = (state == ST_IDLE) ? PWRITE   : write_p0;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (setup) begin
                    capture   = 1'b1;
                    state_nxt = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == 4'd1) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (!PSEL) begin
                    state_nxt = ST_IDLE;
                end else if (PENABLE) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign enter_ready = (state_nxt == ST_READY) && (state != ST_READY);

    always_comb begin
        case (sel_idx)
            ID_IDX:  rd_word = {SLAVE_ID, 24'h0};
            CNT_IDX: rd_word = xfer_cnt;
            default: rd_word = rf_rdata;
        endcase
    end

    apb_slave_regfile #(
        .NUM_WORDS (NUM_WORDS)
    ) u_regfile (
        .PCLK  (PCLK),
        .clr   (PRESET),
        .we    (commit && write_p0 && !err_p0),
        .waddr (idx_p0),
        .wdata (wdata_p0),
        .raddr (sel_idx),
        .rdata (rf_rdata)
    );

    // Setup capture: data-path registers, not reset
    always_ff @(posedge PCLK) begin
        if (capture) begin
            idx_p0   <= live_idx;
            write_p0 <= PWRITE;
            err_p0   <= live_err;
            wdata_p0 <= PWDATA;
        end
    end

    // Control state and registered bus outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            xfer_cnt <= '0;
            PRDATA   <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (capture) begin
                wait_cnt <= WAIT_W'(WAIT_CYCLES);
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (commit && !err_p0) begin
                xfer_cnt <= xfer_cnt + 32'd1;
            end

            PREADY  <= (state_nxt == ST_READY);
            PSLVERR <= (state_nxt == ST_READY) && sel_err;

            // Read data is sampled once on READY entry and held; this also
            // gives the counter its pre-increment value.
            if (enter_ready) begin
                PRDATA <= (sel_err || sel_wr) ? '0 : rd_word;
            end else if (state_nxt != ST_READY) begin
                PRDATA <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_regbank_slave
// Directed bench for apb_regbank_slave: one instance with two wait states
// (index 0) and one with none (index 1), both SLAVE_ID=8'h01, 64 words.
// ---------------------------------------------------------------------------
module tb_apb_regbank_slave;

    logic        clk = 1'b0;
    logic        preset;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_regbank_slave #(
        .SLAVE_ID    (8'h01),
        .NUM_WORDS   (64),
        .WAIT_CYCLES (2)
    ) u_slow (
        .PCLK    (clk),
        .PRESET  (preset),
        .PSEL    (psel[0]),
        .PENABLE (penable[0]),
        .PWRITE  (pwrite[0]),
        .PADDR   (paddr[0]),
        .PWDATA  (pwdata[0]),
        .PRDATA  (prdata[0]),
        .PREADY  (pready[0]),
        .PSLVERR (pslverr[0])
    );

    apb_regbank_slave #(
        .SLAVE_ID    (8'h01),
        .NUM_WORDS   (64),
        .WAIT_CYCLES (0)
    ) u_fast (
        .PCLK    (clk),
        .PRESET  (preset),
        .PSEL    (psel[1]),
        .PENABLE (penable[1]),
        .PWRITE  (pwrite[1]),
        .PADDR   (paddr[1]),
        .PWDATA  (pwdata[1]),
        .PRDATA  (prdata[1]),
        .PREADY  (pready[1]),
        .PSLVERR (pslverr[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Full APB transfer on instance d, starting #1 after a rising edge.
    // Checks access-cycle count of PREADY, PSLVERR, PRDATA, and PREADY low
    // in the cycle after commit. keep=1 leaves PSEL up for a back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit keep,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_cyc, input string tag);
        int cyc;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wd;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        cyc = 1;
        while (pready[d] !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_err"},    {31'b0, pslverr[d]}, {31'b0, exp_err});
        chk({tag, "_rdata"},  prdata[d], exp_rd);
        @(posedge clk); #1;
        chk({tag, "_rdy_after"}, {31'b0, pready[d]}, 32'd0);
        if (!keep) begin
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
        end
    endtask

    initial begin
        preset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = '0;  pwdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready",  {31'b0, pready[0]},  32'd0);
        chk("rst_pslverr", {31'b0, pslverr[0]}, 32'd0);
        chk("rst_prdata",  prdata[0], 32'd0);
        chk("rst_pready_f", {31'b0, pready[1]}, 32'd0);
        preset = 1'b0;
        @(posedge clk); #1;

        // Storage write/read with two wait states
        xfer(0, 1'b1, 32'h80010008, 32'h12345678, 0, 32'h0,        1'b0, 3, "wr_w2");
        xfer(0, 1'b0, 32'h80010008, 32'h0,        0, 32'h12345678, 1'b0, 3, "rd_w2");
        // ID register, third good transfer
        xfer(0, 1'b0, 32'h80010000, 32'h0,        0, 32'h01000000, 1'b0, 3, "rd_id");
        // Counter returns pre-increment value
        xfer(0, 1'b0, 32'h80010004, 32'h0,        0, 32'd3,        1'b0, 3, "rd_cnt3");
        xfer(0, 1'b0, 32'h80010004, 32'h0,        0, 32'd4,        1'b0, 3, "rd_cnt4");
        // Read-only and out-of-range/misaligned errors
        xfer(0, 1'b1, 32'h80010000, 32'hDEADBEEF, 0, 32'h0,        1'b1, 3, "wr_id");
        xfer(0, 1'b0, 32'h80010000, 32'h0,        0, 32'h01000000, 1'b0, 3, "rerd_id");
        xfer(0, 1'b0, 32'h80010100, 32'h0,        0, 32'h0,        1'b1, 3, "rd_oor");
        xfer(0, 1'b0, 32'h80010009, 32'h0,        0, 32'h0,        1'b1, 3, "rd_misal");
        xfer(0, 1'b1, 32'h80010004, 32'h55555555, 0, 32'h0,        1'b1, 3, "wr_cnt");
        // Errored transfers are not counted: 6 good so far
        xfer(0, 1'b0, 32'h80010004, 32'h0,        0, 32'd6,        1'b0, 3, "rd_cnt6");

        // Reset during the wait phase of a write
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h8001000C; pwdata[0] = 32'hABCDEF00;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        preset = 1'b1;
        @(posedge clk); #1;
        chk("rstw_pready",  {31'b0, pready[0]},  32'd0);
        chk("rstw_pslverr", {31'b0, pslverr[0]}, 32'd0);
        chk("rstw_prdata",  prdata[0], 32'd0);
        preset = 1'b0;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h80010004, 32'h0, 0, 32'd0, 1'b0, 3, "rstw_cnt");
        xfer(0, 1'b0, 32'h8001000C, 32'h0, 0, 32'h0, 1'b0, 3, "rstw_rd0c");
        xfer(0, 1'b0, 32'h80010008, 32'h0, 0, 32'h0, 1'b0, 3, "rstw_rd08");

        // Abort: PSEL dropped during the wait phase of a write
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h80010010; pwdata[0] = 32'h55AA55AA;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(posedge clk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort_pready", {31'b0, pready[0]}, 32'd0);
        xfer(0, 1'b0, 32'h80010010, 32'h0, 0, 32'h0, 1'b0, 3, "abort_rd");
        xfer(0, 1'b0, 32'h80010004, 32'h0, 0, 32'd4, 1'b0, 3, "abort_cnt");

        // No wait states, back-to-back writes then reads
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1'b1, 32'h80010008 + 32'(4 * i), 32'h11111111 + 32'(i), 1,
                 32'h0, 1'b0, 1, $sformatf("b2b_wr%0d", i));
        end
        xfer(1, 1'b0, 32'h80010004, 32'h0, 1, 32'd4, 1'b0, 1, "b2b_cnt");
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1'b0, 32'h80010008 + 32'(4 * i), 32'h0, (i != 3),
                 32'h11111111 + 32'(i), 1'b0, 1, $sformatf("b2b_rd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
